// File: rtl/dm_store_buffer.sv
// FIFO store buffer in front of the data memory port. Loads win the port
// unless they hit a pending store word, in which case the buffer drains first.
module dm_store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTRW  = 2
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            StReq,
  input  logic [31:0]     StAddr,
  input  logic [31:0]     StWD,
  input  logic            StByte,
  input  logic [31:0]     StPC,
  input  logic            LdReq,
  input  logic [31:0]     LdAddr,
  input  logic            LdByte,
  output logic            StStall,
  output logic            LdStall,
  output logic            Empty,
  output logic [PTRW:0]   Count,
  output logic            DmWE,
  output logic [31:0]     DmAddr,
  output logic [31:0]     DmWD,
  output logic            DmByte,
  output logic [31:0]     DmPC
);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wd;
    logic        byt;
    logic [31:0] pc;
  } ent_t;

  ent_t            mem [DEPTH];
  ent_t            hd;
  logic [PTRW-1:0] head, tail;
  logic [PTRW:0]   cnt;
  logic [DEPTH-1:0] hit;
  logic            conflict, drain, enq;

  // An entry is live when its distance from head is below the count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    logic [PTRW-1:0] off;
    assign off    = PTRW'(g) - head;
    assign hit[g] = ({1'b0, off} < cnt) && (mem[g].addr[31:2] == LdAddr[31:2]);
  end

  assign conflict = |hit;
  assign hd       = mem[head];
  assign StStall  = StReq && (cnt == (PTRW+1)'(DEPTH));
  assign enq      = StReq && !StStall;
  assign drain    = LdReq ? conflict : (cnt != '0);
  assign LdStall  = LdReq && conflict;
  assign Empty    = (cnt == '0);
  assign Count    = cnt;

  always_comb begin
    DmWE   = 1'b0;
    DmAddr = '0;
    DmWD   = '0;
    DmByte = 1'b0;
    DmPC   = '0;
    if (LdReq && !conflict) begin
      DmAddr = LdAddr;
      DmByte = LdByte;
    end else if (drain) begin
      DmWE   = 1'b1;
      DmAddr = hd.addr;
      DmWD   = hd.wd;
      DmByte = hd.byt;
      DmPC   = hd.pc;
    end
  end

  always_ff @(posedge Clk) begin
    if (enq) mem[tail] <= '{addr: StAddr, wd: StWD, byt: StByte, pc: StPC};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (enq)   tail <= tail + 1'b1;
      if (drain) head <= head + 1'b1;
      case ({enq, drain})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Bench for dm_store_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_dm_store_buffer;
  localparam int DEPTH = 4;
  localparam int PTRW  = 2;

  logic        Clk = 1'b0, Reset = 1'b1;
  logic        StReq = 0, StByte = 0, LdReq = 0, LdByte = 0;
  logic [31:0] StAddr = 0, StWD = 0, StPC = 0, LdAddr = 0;
  logic        StStall, LdStall, Empty, DmWE, DmByte;
  logic [PTRW:0] Count;
  logic [31:0] DmAddr, DmWD, DmPC;

  dm_store_buffer #(.DEPTH(DEPTH), .PTRW(PTRW)) dut (
    .Clk(Clk), .Reset(Reset),
    .StReq(StReq), .StAddr(StAddr), .StWD(StWD), .StByte(StByte), .StPC(StPC),
    .LdReq(LdReq), .LdAddr(LdAddr), .LdByte(LdByte),
    .StStall(StStall), .LdStall(LdStall), .Empty(Empty), .Count(Count),
    .DmWE(DmWE), .DmAddr(DmAddr), .DmWD(DmWD), .DmByte(DmByte), .DmPC(DmPC)
  );

  always #5 Clk = ~Clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending stores in issue order
  typedef struct {
    logic [31:0] addr, wd, pc;
    logic        byt;
  } st_t;
  st_t mq[$];
  bit  started = 0;
  bit  logging = 0;
  logic [63:0] dlog[$];

  function automatic bit mconf(input logic [31:0] la);
    foreach (mq[i]) if (mq[i].addr[31:2] == la[31:2]) return 1;
    return 0;
  endfunction

  always @(posedge Clk) begin
    if (Reset) begin
      mq.delete();
      started = 1;
    end else if (started) begin
      bit dr, en;
      dr = LdReq ? mconf(LdAddr) : (mq.size() > 0);
      en = StReq && (mq.size() < DEPTH);
      if (dr) void'(mq.pop_front());
      if (en) mq.push_back('{addr: StAddr, wd: StWD, pc: StPC, byt: StByte});
    end
  end

  always @(negedge Clk) begin
    if (started) begin
      logic        ewe, ebyte, els;
      logic [31:0] eaddr, ewd, epc;
      bit cf;
      cf = mconf(LdAddr);
      ewe = 0; ebyte = 0; eaddr = 0; ewd = 0; epc = 0;
      els = LdReq && cf;
      if (LdReq && !cf) begin
        eaddr = LdAddr; ebyte = LdByte;
      end else if (mq.size() > 0) begin
        ewe = 1; eaddr = mq[0].addr; ewd = mq[0].wd; epc = mq[0].pc; ebyte = mq[0].byt;
      end
      chk("m_StStall", 32'(StStall), 32'(StReq && mq.size() == DEPTH));
      chk("m_LdStall", 32'(LdStall), 32'(els));
      chk("m_Empty",   32'(Empty),   32'(mq.size() == 0));
      chk("m_Count",   32'(Count),   32'(mq.size()));
      chk("m_DmWE",    32'(DmWE),    32'(ewe));
      chk("m_DmAddr",  DmAddr,       eaddr);
      chk("m_DmWD",    DmWD,         ewd);
      chk("m_DmByte",  32'(DmByte),  32'(ebyte));
      chk("m_DmPC",    DmPC,         epc);
      if (logging && DmWE) dlog.push_back({DmAddr, DmWD});
    end
  end

  task automatic cyc(); @(posedge Clk); #1; endtask
  task automatic smp(); @(negedge Clk); endtask
  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [31:0] pc, input logic b);
    StReq = 1; StAddr = a; StWD = d; StPC = pc; StByte = b;
  endtask

  logic [31:0] sa [5];

  initial begin
    sa[0] = 32'h0; sa[1] = 32'h4; sa[2] = 32'h8; sa[3] = 32'hC; sa[4] = 32'h14;

    // Reset and a single sw
    cyc(); Reset = 0;
    smp();
    chk("rst_Empty", 32'(Empty), 1); chk("rst_StStall", 32'(StStall), 0);
    chk("rst_LdStall", 32'(LdStall), 0); chk("rst_DmWE", 32'(DmWE), 0);
    chk("rst_Count", 32'(Count), 0);
    cyc(); st(32'h10, 32'hDEADBEEF, 32'h3000, 0);
    smp(); chk("sw_nolat_DmWE", 32'(DmWE), 0);
    cyc(); StReq = 0;
    smp();
    chk("sw_Count1", 32'(Count), 1); chk("sw_DmWE", 32'(DmWE), 1);
    chk("sw_DmAddr", DmAddr, 32'h10); chk("sw_DmWD", DmWD, 32'hDEADBEEF);
    chk("sw_DmPC", DmPC, 32'h3000);
    cyc(); smp();
    chk("sw_Count0", 32'(Count), 0); chk("sw_Empty", 32'(Empty), 1);

    // Fill under a non-matching load; fifth store stalls
    cyc(); LdReq = 1; LdAddr = 32'h100; LdByte = 0;
    for (int k = 0; k < 5; k++) begin
      st(sa[k], 32'h1000 + sa[k], 32'h4000 + sa[k], 0);
      smp();
      chk("fill_DmWE", 32'(DmWE), 0);
      chk("fill_DmAddr", DmAddr, 32'h100);
      if (k == 4) begin
        chk("fill_StStall", 32'(StStall), 1); chk("fill_Count4", 32'(Count), 4);
      end
      if (k < 4) cyc();
    end

    // Drop the load: FIFO drain, retried store held for one more cycle
    cyc(); LdReq = 0;
    smp(); chk("dr0_Addr", DmAddr, 32'h0); chk("dr0_StStall", 32'(StStall), 1);
    chk("dr0_WD", DmWD, 32'h1000);
    cyc(); smp();
    chk("dr1_Addr", DmAddr, 32'h4); chk("dr1_StStall", 32'(StStall), 0);
    chk("dr1_Count", 32'(Count), 3);
    cyc(); StReq = 0;
    smp(); chk("dr2_Addr", DmAddr, 32'h8);
    cyc(); smp(); chk("dr3_Addr", DmAddr, 32'hC);
    cyc(); smp(); chk("dr4_Addr", DmAddr, 32'h14); chk("dr4_WE", 32'(DmWE), 1);
    cyc(); smp(); chk("dr5_Empty", 32'(Empty), 1); chk("dr5_WE", 32'(DmWE), 0);

    // sb then conflicting lb in the same word
    cyc(); st(32'h21, 32'hAB, 32'h5000, 1);
    smp(); chk("sb_WE", 32'(DmWE), 0);
    cyc(); StReq = 0; StByte = 0; LdReq = 1; LdAddr = 32'h22; LdByte = 1;
    smp();
    chk("lb_LdStall1", 32'(LdStall), 1); chk("lb_WE1", 32'(DmWE), 1);
    chk("lb_Addr1", DmAddr, 32'h21); chk("lb_Byte1", 32'(DmByte), 1);
    chk("lb_WD1", DmWD, 32'hAB);
    cyc(); smp();
    chk("lb_LdStall2", 32'(LdStall), 0); chk("lb_Addr2", DmAddr, 32'h22);
    chk("lb_Byte2", 32'(DmByte), 1); chk("lb_WE2", 32'(DmWE), 0);

    // Reset in the middle of a drain
    cyc(); LdAddr = 32'h200; LdByte = 0;
    st(32'h40, 32'h40, 32'h7000, 0); cyc();
    st(32'h44, 32'h44, 32'h7004, 0); cyc();
    st(32'h48, 32'h48, 32'h7008, 0); cyc();
    StReq = 0; LdReq = 0;
    smp(); chk("mr_WE", 32'(DmWE), 1); chk("mr_Addr", DmAddr, 32'h40);
    chk("mr_Count", 32'(Count), 3);
    cyc(); Reset = 1;
    cyc(); Reset = 0;
    smp(); chk("mr_Count0", 32'(Count), 0); chk("mr_WE0", 32'(DmWE), 0);
    chk("mr_Empty", 32'(Empty), 1);
    cyc(); smp(); chk("mr_WE1", 32'(DmWE), 0);

    // Ten stores with interleaved drains: pointers wrap
    cyc(); logging = 1; LdAddr = 32'h300;
    for (int k = 0; k < 10; k++) begin
      st(32'h80 + 4 * k, 32'hA000_0000 + k, 32'h6000 + 4 * k, 0);
      LdReq = (k % 3 == 0);
      cyc();
    end
    StReq = 0; LdReq = 0;
    for (int w = 0; w < 20 && !Empty; w++) cyc();
    smp(); logging = 0;
    chk("wrap_Empty", 32'(Empty), 1);
    chk("wrap_nwrites", dlog.size(), 10);
    for (int k = 0; k < 10 && k < dlog.size(); k++) begin
      chk("wrap_addr", dlog[k][63:32], 32'h80 + 4 * k);
      chk("wrap_data", dlog[k][31:0], 32'hA000_0000 + k);
    end

    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end
endmodule
